// File: rtl/ternary_alu_sequencer.sv
// Request-side initiator for a registered ternary ALU: issues one operation per
// request, captures the result after ALU_LATENCY edges, optionally checks it.
`timescale 1ns/1ps

module ternary_alu_sequencer #(
    parameter int WORD_SIZE   = 9,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [5:0]               req_opcode,
    input  logic [2*WORD_SIZE-1:0]   req_a,
    input  logic [2*WORD_SIZE-1:0]   req_b,
    input  logic [2*WORD_SIZE-1:0]   req_expected,
    input  logic                     req_check,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*WORD_SIZE-1:0]   rsp_result,
    output logic                     rsp_mismatch,
    output logic                     rsp_invalid,

    output logic [5:0]               opcode,
    output logic [2*WORD_SIZE-1:0]   input1,
    output logic [2*WORD_SIZE-1:0]   input2,
    output logic                     alu_enable,
    input  logic [2*WORD_SIZE-1:0]   alu_out,

    input  logic                     clear_counts,
    output logic [CNT_WIDTH-1:0]     pass_count,
    output logic [CNT_WIDTH-1:0]     fail_count,
    output logic                     busy
);

    localparam int W      = 2 * WORD_SIZE;
    localparam int WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ALU_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [5:0]           opcode_q, opcode_d;
    logic [W-1:0]         input1_q, input1_d;
    logic [W-1:0]         input2_q, input2_d;
    logic [W-1:0]         expected_q, expected_d;
    logic                 check_q, check_d;
    logic [W-1:0]         result_q, result_d;
    logic                 mismatch_q, mismatch_d;
    logic                 invalid_q, invalid_d;
    logic [CNT_WIDTH-1:0] pass_q, pass_d;
    logic [CNT_WIDTH-1:0] fail_q, fail_d;

    logic                 accept;
    logic                 capture;
    logic                 result_invalid;
    logic                 result_mismatch;

    // Ready is gated by reset so nothing is accepted before the state register is known.
    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign capture   = (state_q == S_WAIT) && (wait_cnt_q == '0);

    always_comb begin
        result_invalid = 1'b0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            if (alu_out[2*i +: 2] == 2'b10) begin
                result_invalid = 1'b1;
            end
        end
    end

    assign result_mismatch = check_q && (result_invalid || (alu_out != expected_q));

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        opcode_d   = opcode_q;
        input1_d   = input1_q;
        input2_d   = input2_q;
        expected_d = expected_q;
        check_d    = check_q;
        result_d   = result_q;
        mismatch_d = mismatch_q;
        invalid_d  = invalid_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opcode_d   = req_opcode;
                    input1_d   = req_a;
                    input2_d   = req_b;
                    expected_d = req_expected;
                    check_d    = req_check;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // WAIT spans ALU_LATENCY cycles; the capture happens when the count reaches zero.
                wait_cnt_d = WAIT_LOAD;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (capture) begin
                    result_d   = alu_out;
                    mismatch_d = result_mismatch;
                    invalid_d  = result_invalid;
                    state_d    = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        if (clear_counts) begin
            pass_d = '0;
            fail_d = '0;
        end else if (capture && check_q) begin
            if (result_mismatch) begin
                fail_d = (fail_q == '1) ? fail_q : fail_q + CNT_WIDTH'(1);
            end else begin
                pass_d = (pass_q == '1) ? pass_q : pass_q + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            opcode_q   <= '0;
            input1_q   <= '0;
            input2_q   <= '0;
            expected_q <= '0;
            check_q    <= 1'b0;
            result_q   <= '0;
            mismatch_q <= 1'b0;
            invalid_q  <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opcode_q   <= opcode_d;
            input1_q   <= input1_d;
            input2_q   <= input2_d;
            expected_q <= expected_d;
            check_q    <= check_d;
            result_q   <= result_d;
            mismatch_q <= mismatch_d;
            invalid_q  <= invalid_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    assign alu_enable   = (state_q == S_ISSUE);
    assign rsp_valid    = (state_q == S_RESP);
    assign busy         = (state_q != S_IDLE);
    assign opcode       = opcode_q;
    assign input1       = input1_q;
    assign input2       = input2_q;
    assign rsp_result   = result_q;
    assign rsp_mismatch = mismatch_q;
    assign rsp_invalid  = invalid_q;
    assign pass_count   = pass_q;
    assign fail_count   = fail_q;

endmodule

// File: tb/tb_ternary_alu_sequencer.sv
// Bench for ternary_alu_sequencer: three instances (latency 1, latency 3, 2-bit counters)
// each driven against a small registered stub ALU; only one instance is out of reset at a time.
`timescale 1ns/1ps

module tb_ternary_alu_sequencer;

    localparam int WS = 9;
    localparam int W  = 2 * WS;
    localparam logic [5:0]   OP_ADD = 6'b000001;
    localparam logic [5:0]   OP_SUB = 6'b000011;
    localparam logic [5:0]   OP_BAD = 6'b000100;
    localparam logic [W-1:0] JUNK   = 18'h15555;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]   rst;
    logic         req_valid;
    logic [5:0]   req_opcode;
    logic [W-1:0] req_a, req_b, req_expected;
    logic         req_check;
    logic         rsp_ready;
    logic         clear_counts;

    logic [2:0]   req_ready, rsp_valid, rsp_mismatch, rsp_invalid, alu_enable, busy;
    logic [W-1:0] rsp_result [3];
    logic [W-1:0] input1 [3];
    logic [W-1:0] input2 [3];
    logic [W-1:0] alu_out [3];
    logic [5:0]   opcode [3];
    logic [15:0]  pass_c [2];
    logic [15:0]  fail_c [2];
    logic [1:0]   pass_s, fail_s;

    ternary_alu_sequencer #(.WORD_SIZE(WS), .ALU_LATENCY(1), .CNT_WIDTH(16)) u_dut0 (
        .clock(clock), .reset(rst[0]),
        .req_valid(req_valid), .req_ready(req_ready[0]), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_expected(req_expected), .req_check(req_check),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_result(rsp_result[0]),
        .rsp_mismatch(rsp_mismatch[0]), .rsp_invalid(rsp_invalid[0]),
        .opcode(opcode[0]), .input1(input1[0]), .input2(input2[0]),
        .alu_enable(alu_enable[0]), .alu_out(alu_out[0]),
        .clear_counts(clear_counts), .pass_count(pass_c[0]), .fail_count(fail_c[0]),
        .busy(busy[0])
    );

    ternary_alu_sequencer #(.WORD_SIZE(WS), .ALU_LATENCY(3), .CNT_WIDTH(16)) u_dut1 (
        .clock(clock), .reset(rst[1]),
        .req_valid(req_valid), .req_ready(req_ready[1]), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_expected(req_expected), .req_check(req_check),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_result(rsp_result[1]),
        .rsp_mismatch(rsp_mismatch[1]), .rsp_invalid(rsp_invalid[1]),
        .opcode(opcode[1]), .input1(input1[1]), .input2(input2[1]),
        .alu_enable(alu_enable[1]), .alu_out(alu_out[1]),
        .clear_counts(clear_counts), .pass_count(pass_c[1]), .fail_count(fail_c[1]),
        .busy(busy[1])
    );

    ternary_alu_sequencer #(.WORD_SIZE(WS), .ALU_LATENCY(1), .CNT_WIDTH(2)) u_dut2 (
        .clock(clock), .reset(rst[2]),
        .req_valid(req_valid), .req_ready(req_ready[2]), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_expected(req_expected), .req_check(req_check),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_result(rsp_result[2]),
        .rsp_mismatch(rsp_mismatch[2]), .rsp_invalid(rsp_invalid[2]),
        .opcode(opcode[2]), .input1(input1[2]), .input2(input2[2]),
        .alu_enable(alu_enable[2]), .alu_out(alu_out[2]),
        .clear_counts(clear_counts), .pass_count(pass_s), .fail_count(fail_s),
        .busy(busy[2])
    );

    function automatic int to_int(input logic [W-1:0] v);
        int acc;
        acc = 0;
        for (int i = WS - 1; i >= 0; i--) begin
            acc = acc * 3;
            if (v[2*i +: 2] == 2'b01) acc = acc + 1;
            else if (v[2*i +: 2] == 2'b11) acc = acc - 1;
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] from_int(input int v);
        logic [W-1:0] r;
        int x;
        int m;
        r = '0;
        x = v;
        for (int i = 0; i < WS; i++) begin
            m = ((x % 3) + 3) % 3;
            if (m == 1) begin
                r[2*i +: 2] = 2'b01;
                x = (x - 1) / 3;
            end else if (m == 2) begin
                r[2*i +: 2] = 2'b11;
                x = (x + 1) / 3;
            end else begin
                x = x / 3;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] stub_f(input logic [5:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            OP_ADD: r = from_int(to_int(a) + to_int(b));
            OP_SUB: r = from_int(to_int(a) - to_int(b));
            OP_BAD: begin
                r = a;
                r[1:0] = 2'b10;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Stub ALU pipelines: junk enters on non-enable cycles so an early or late capture shows up.
    logic [W-1:0] pipe [3][3];
    int en_cnt [3] = '{0, 0, 0};

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            pipe[k][0] <= alu_enable[k] ? stub_f(opcode[k], input1[k], input2[k]) : JUNK;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
            if (alu_enable[k]) en_cnt[k] <= en_cnt[k] + 1;
        end
    end

    assign alu_out[0] = pipe[0][0];
    assign alu_out[1] = pipe[1][2];
    assign alu_out[2] = pipe[2][0];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int lat_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic int get_pass(input int k);
        if (k == 2) return int'(pass_s);
        return int'(pass_c[k]);
    endfunction

    function automatic int get_fail(input int k);
        if (k == 2) return int'(fail_s);
        return int'(fail_c[k]);
    endfunction

    // Leaves the caller 1 time unit after the accept edge (ISSUE cycle).
    task automatic send_req(input int k, input logic [5:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp, input logic chk);
        int n;
        req_opcode   = op;
        req_a        = a;
        req_b        = b;
        req_expected = exp;
        req_check    = chk;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_before_accept", 32'(req_ready[k]), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int k, output int lat);
        lat = 0;
        while (!rsp_valid[k] && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input int k, input logic [5:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input logic chk,
                         input logic [W-1:0] exp_res, input logic exp_mm, input logic exp_inv,
                         input int exp_pass, input int exp_fail);
        int e0;
        int lat;
        e0 = en_cnt[k];
        send_req(k, op, a, b, exp, chk);
        check("alu_enable_in_issue", 32'(alu_enable[k]), 32'd1);
        check("opcode_out", 32'(opcode[k]), 32'(op));
        check("input2_out", 32'(input2[k]), 32'(b));
        wait_rsp(k, lat);
        check("rsp_latency", lat, 1 + lat_of(k));
        check("alu_enable_pulses", en_cnt[k] - e0, 1);
        check("input1_held", 32'(input1[k]), 32'(a));
        check("rsp_result", 32'(rsp_result[k]), 32'(exp_res));
        check("rsp_mismatch", 32'(rsp_mismatch[k]), 32'(exp_mm));
        check("rsp_invalid", 32'(rsp_invalid[k]), 32'(exp_inv));
        check("pass_count", get_pass(k), exp_pass);
        check("fail_count", get_fail(k), exp_fail);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_dropped", 32'(rsp_valid[k]), 32'd0);
        check("req_ready_back", 32'(req_ready[k]), 32'd1);
    endtask

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic         chk;
        logic [W-1:0] res;
        logic         mm;
        logic         inv;
        int           exp_pass;
        int           exp_fail;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int e0;
        logic saw;

        // 118 = 0x151, -1 = 0x003, 117 = 0x150, 2 = 0x007 (+1,-1), 1 = 0x001
        vecs[0] = '{OP_ADD, 18'h151, 18'h003, 18'h150, 1'b1, 18'h150, 1'b0, 1'b0, 1, 0};
        vecs[1] = '{OP_ADD, 18'h151, 18'h003, 18'h151, 1'b1, 18'h150, 1'b1, 1'b0, 1, 1};
        vecs[2] = '{OP_BAD, 18'h151, 18'h000, 18'h000, 1'b0, 18'h152, 1'b0, 1'b1, 1, 1};
        vecs[3] = '{OP_BAD, 18'h151, 18'h000, 18'h152, 1'b1, 18'h152, 1'b1, 1'b1, 1, 2};
        vecs[4] = '{OP_SUB, 18'h151, 18'h151, 18'h000, 1'b1, 18'h000, 1'b0, 1'b0, 2, 2};
        vecs[5] = '{OP_ADD, 18'h001, 18'h001, 18'h007, 1'b0, 18'h007, 1'b0, 1'b0, 2, 2};
        vecs[6] = '{OP_ADD, 18'h001, 18'h001, 18'h000, 1'b0, 18'h007, 1'b0, 1'b0, 2, 2};
        vecs[7] = '{OP_SUB, 18'h000, 18'h001, 18'h003, 1'b1, 18'h003, 1'b0, 1'b0, 3, 2};

        rst          = 3'b111;
        req_valid    = 1'b0;
        req_opcode   = '0;
        req_a        = '0;
        req_b        = '0;
        req_expected = '0;
        req_check    = 1'b0;
        rsp_ready    = 1'b0;
        clear_counts = 1'b0;
        repeat (2) tick();

        check("rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("rst_alu_enable", 32'(alu_enable[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_opcode", 32'(opcode[0]), 32'd0);
        check("rst_input1", 32'(input1[0]), 32'd0);
        check("rst_input2", 32'(input2[0]), 32'd0);
        check("rst_rsp_result", 32'(rsp_result[0]), 32'd0);
        check("rst_rsp_mismatch", 32'(rsp_mismatch[0]), 32'd0);
        check("rst_rsp_invalid", 32'(rsp_invalid[0]), 32'd0);
        check("rst_pass", get_pass(0), 0);
        check("rst_fail", get_fail(0), 0);

        rst[0] = 1'b0;
        tick();
        check("ready_after_reset", 32'(req_ready[0]), 32'd1);

        for (int i = 0; i < 8; i++) begin
            do_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].chk,
                  vecs[i].res, vecs[i].mm, vecs[i].inv, vecs[i].exp_pass, vecs[i].exp_fail);
        end

        // Backpressure: response stalled 5 cycles with a second request waiting.
        send_req(0, OP_ADD, 18'h001, 18'h001, 18'h007, 1'b1);
        wait_rsp(0, lat);
        check("bp_latency", lat, 2);
        req_opcode   = OP_SUB;
        req_a        = 18'h000;
        req_b        = 18'h001;
        req_expected = 18'h003;
        req_check    = 1'b1;
        req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_rsp_result", 32'(rsp_result[0]), 32'h007);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
            check("bp_opcode_held", 32'(opcode[0]), 32'(OP_ADD));
            check("bp_pass_once", get_pass(0), 4);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_idle_ready", 32'(req_ready[0]), 32'd1);
        check("bp_rsp_valid_low", 32'(rsp_valid[0]), 32'd0);
        check("bp_result_stable", 32'(rsp_result[0]), 32'h007);
        tick();
        req_valid = 1'b0;
        check("bp_second_accepted", 32'(busy[0]), 32'd1);
        check("bp_second_enable", 32'(alu_enable[0]), 32'd1);
        check("bp_second_opcode", 32'(opcode[0]), 32'(OP_SUB));
        wait_rsp(0, lat);
        check("bp_second_result", 32'(rsp_result[0]), 32'h003);
        check("bp_second_pass", get_pass(0), 5);
        check("bp_second_fail", get_fail(0), 2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Latency 3: reset during WAIT drops the operation.
        rst[0] = 1'b1;
        rst[1] = 1'b0;
        tick();
        e0 = en_cnt[1];
        send_req(1, OP_ADD, 18'h151, 18'h003, 18'h150, 1'b1);
        tick();
        tick();
        rst[1] = 1'b1;
        tick();
        check("midrst_busy", 32'(busy[1]), 32'd0);
        check("midrst_alu_enable", 32'(alu_enable[1]), 32'd0);
        check("midrst_req_ready", 32'(req_ready[1]), 32'd0);
        rst[1] = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            saw = saw | rsp_valid[1] | alu_enable[1];
            tick();
        end
        check("midrst_no_response", 32'(saw), 32'd0);
        check("midrst_pass", get_pass(1), 0);
        check("midrst_fail", get_fail(1), 0);
        check("midrst_one_issue", en_cnt[1] - e0, 1);
        do_op(1, OP_ADD, 18'h151, 18'h003, 18'h150, 1'b1, 18'h150, 1'b0, 1'b0, 1, 0);

        // 2-bit counters: saturation and clear racing a capture.
        rst[1] = 1'b1;
        rst[2] = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            do_op(2, OP_ADD, 18'h001, 18'h001, 18'h007, 1'b1, 18'h007, 1'b0, 1'b0,
                  (i < 3) ? i + 1 : 3, 0);
        end
        send_req(2, OP_ADD, 18'h001, 18'h001, 18'h007, 1'b1);
        tick();
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        check("clear_vs_inc_pass", get_pass(2), 0);
        check("clear_vs_inc_fail", get_fail(2), 0);
        check("clear_keeps_rsp", 32'(rsp_valid[2]), 32'd1);
        check("clear_rsp_result", 32'(rsp_result[2]), 32'h007);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_op(2, OP_ADD, 18'h001, 18'h001, 18'h000, 1'b1, 18'h007, 1'b1, 1'b0,
                  0, (i < 3) ? i + 1 : 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ternary_alu_sequencer.md
# ternary_alu_sequencer

- Request-side initiator for the 9-trit `ternary_alu`.
- Accepts one operation per valid/ready request and drives `opcode`, `input1`, `input2` and a one-cycle `alu_enable` pulse into the ALU.
- Waits out the ALU's registered latency, captures `alu_out`, and returns it on a valid/ready response channel.
- Can optionally check the result against an expected value, keeping saturating pass/fail counters. This gives the processor and on-chip self-test the same driver.

## Interface
Parameters:
- `WORD_SIZE`, default 9: trits per word; buses are 2*WORD_SIZE bits. Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1, 2'b10 = invalid.
- `ALU_LATENCY`, default 1: clock edges from the `alu_enable` cycle until `alu_out` is valid; must be ≥ 1.
- `CNT_WIDTH`, default 16: width of the pass/fail counters.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at an edge.
- `req_opcode`  in  6  3-trit opcode.
- `req_a`, `req_b`  in  2*WORD_SIZE  operands.
- `req_expected`  in  2*WORD_SIZE  expected result.
- `req_check`  in  1  compare the result and update the counters.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_result`  out  2*WORD_SIZE  captured `alu_out`.
- `rsp_mismatch`  out  1  checked result differs from expected, or contains an invalid trit.
- `rsp_invalid`  out  1  result contains any 2'b10 trit.
- `opcode`  out  6  to ALU.
- `input1`, `input2`  out  2*WORD_SIZE  to ALU.
- `alu_enable`  out  1  to ALU.
- `alu_out`  in  2*WORD_SIZE  from ALU.
- `clear_counts`  in  1  synchronous clear of both counters.
- `pass_count`, `fail_count`  out  CNT_WIDTH  saturating counters.
- `busy`  out  1  state ≠ IDLE.

## Operation
FSM states and transitions:
- IDLE: `req_ready` = 1. On accept, register opcode, operands, expected value and check flag, then go to ISSUE.
- ISSUE: one cycle; `alu_enable` = 1. Always go to WAIT.
- WAIT: `ALU_LATENCY` cycles, counted by a down-counter; `alu_enable` = 0. At the last WAIT edge, capture `alu_out` into `rsp_result`, compute the mismatch and invalid flags, update the counters, then go to RESP.
- RESP: `rsp_valid` = 1. On `rsp_valid && rsp_ready`, go to IDLE.

Output and check rules:
- `opcode`, `input1` and `input2` hold the registered request from acceptance until the next acceptance. They never change during ISSUE or WAIT.
- `rsp_invalid`: OR over all trits of (trit == 2'b10).
- `rsp_mismatch` = `req_check` AND (`rsp_invalid` OR result ≠ expected, bitwise). It is forced to 0 when `req_check` = 0.

Counters:
- Update only when `req_check` = 1: `pass_count` +1 if not mismatch, otherwise `fail_count` +1.
- Both saturate at 2^CNT_WIDTH−1.
- `clear_counts` zeroes both and takes priority over a same-cycle increment.
- `clear_counts` does not affect the FSM.
- `rsp_result`, `rsp_mismatch` and `rsp_invalid` stay stable until the next capture.

## Timing
Reset values:
- State IDLE; wait counter 0.
- `alu_enable`, `rsp_valid`, `rsp_mismatch`, `rsp_invalid`, `busy` = 0.
- `opcode`, `input1`, `input2`, `rsp_result`, `pass_count`, `fail_count` = 0.
- `req_ready` = 0 while `reset` is high; 1 from the first cycle after `reset` falls.

Latency and throughput:
- Request accepted at edge E0. ISSUE runs in cycle E0→E1 and the ALU registers its output at E1.
- Capture happens at edge E0+1+ALU_LATENCY.
- `rsp_valid` is high from that edge: 2 cycles after acceptance for the default latency.
- Best-case throughput is one operation per 3+ALU_LATENCY cycles: IDLE, ISSUE, WAIT×L, RESP with `rsp_ready` already high.

Handshake rules:
- `req_ready` is 0 in every state except IDLE, so a request is never accepted while a response is pending.
- Backpressure: RESP holds `rsp_valid` and the response data indefinitely while `rsp_ready` = 0.
- The counters update once per operation, at capture time, regardless of how long the response is stalled.

Reset mid-operation: at the reset edge, return to IDLE and drop the operation. No response is issued and no counter is updated. `alu_enable` is 0 in the cycle after the reset edge.

## Test plan
The bench pairs the block with `ternary_alu`, or with a stub model for the invalid-trit and latency cases.
- ADD, a = [0,0,0,0,1,1,1,0,1] (118), b = [0,…,0,−1], expected [0,0,0,0,1,1,1,0,0] (117), check = 1 → `rsp_valid` 2 cycles after accept, `rsp_result` = 117, `rsp_mismatch` = 0, `pass_count` = 1, `alu_enable` high exactly 1 cycle.
- Same ADD with expected = 118 → `rsp_mismatch` = 1, `fail_count` = 1, `pass_count` unchanged.
- Stub ALU returns 2'b10 in trit 0 with check = 0 → `rsp_invalid` = 1, `rsp_mismatch` = 0, counters unchanged.
- Hold `rsp_ready` = 0 for 5 cycles with `req_valid` = 1 → `rsp_valid` and `rsp_result` stable, `req_ready` = 0. Release `rsp_ready` → IDLE next cycle and the second request is accepted.
- `ALU_LATENCY` = 3 stub; assert `reset` during WAIT → no `rsp_valid`, counters 0, `alu_enable` 0. A fresh request then completes 4 cycles after accept.
- `CNT_WIDTH` = 2, five passing checks → `pass_count` saturates at 3. `clear_counts` coincident with a sixth pass → `pass_count` = 0.
